mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 5 +
 rtl/mem_arbiter.sv | 80 ++++++++
 tb/tb_mem_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU bus word type and memory arbiter defaults
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  localparam logic [7:0] MEM_TIMEOUT = 8'd255;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and data access with a watchdog abort
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = MEM_TIMEOUT
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  iREN,
  input  word_t iaddr,
  output logic  iwait,
  output word_t iload,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  output logic  dwait,
  output word_t dload,
  output logic  ramREN,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  input  word_t ramload,
  input  logic  ram_ready,
  output logic  timeout
);
  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;
  state_t state;
  logic last_data, write_q;
  word_t addr_q, store_q;
  logic [7:0] cnt;
  always_comb begin
    iwait = !(state == IACC && ram_ready);
    dwait = !(state == DACC && ram_ready);
    iload = iwait ? '0 : ramload;
    dload = dwait ? '0 : ramload;
    ramREN = state == IACC || (state == DACC && !write_q);
    ramWEN = state == DACC && write_q;
  end
  assign ramaddr = addr_q;
  assign ramstore = store_q;
  // a tie goes to the side not served last; an abort leaves last_data untouched
  always_ff @(posedge CLK)
    if (RST) begin
      state <= IDLE;
      last_data <= 1'b1;
      write_q <= 1'b0;
      addr_q <= '0;
      store_q <= '0;
      cnt <= '0;
      timeout <= 1'b0;
    end else
      case (state)
        IDLE:
          if ((dREN || dWEN) && (!iREN || !last_data)) begin
            state <= DACC;
            addr_q <= daddr;
            store_q <= dstore;
            write_q <= dWEN;
            cnt <= '0;
          end else if (iREN) begin
            state <= IACC;
            addr_q <= iaddr;
            write_q <= 1'b0;
            cnt <= '0;
          end
        IACC, DACC:
          if (ram_ready) begin
            state <= IDLE;
            last_data <= state == DACC;
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt + 8'd1 >= TIMEOUT) begin
              state <= IDLE;
              timeout <= 1'b1;
            end
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a completion scoreboard for mem_arbiter
module tb_mem_arbiter;
  import cpu_types_pkg::*;
  typedef struct {
    logic d;
    logic wr;
    word_t addr;
    word_t store;
    word_t load;
  } exp_t;
  logic CLK = 0, RST = 1;
  logic iREN = 0, dREN = 0, dWEN = 0, ram_ready = 0;
  word_t iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic iwait, dwait, ramREN, ramWEN, timeout;
  word_t iload, dload, ramaddr, ramstore;
  int checks = 0, errors = 0;
  exp_t sb[$];
  mem_arbiter #(.TIMEOUT(8'd4)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .timeout(timeout)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic do_reset();
    RST = 1;
    iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
    tick();
    tick();
    RST = 0;
  endtask
  task automatic check_idle(input string tag);
    @(negedge CLK);
    check({tag, "_waits"}, {30'd0, iwait, dwait}, 32'd3);
    check({tag, "_strobes"}, {30'd0, ramREN, ramWEN}, 32'd0);
    check({tag, "_loads"}, iload | dload, 32'd0);
  endtask
  // waits for the grant, holds ram_ready low for lat cycles, then completes with load
  task automatic serve(input int lat, input word_t load, input logic d, input logic wr,
                       input word_t addr, input word_t store);
    int n = 0;
    exp_t e;
    while (!(ramREN || ramWEN) && n < 8) begin
      tick();
      n++;
    end
    check("grant_latency", 32'(n), 32'd1);
    repeat (lat) tick();
    ram_ready = 1;
    ramload = load;
    e = '{d, wr, addr, store, load};
    sb.push_back(e);
    tick();
    ram_ready = 0;
  endtask
  always @(negedge CLK)
    if (!iwait || !dwait) begin
      if (sb.size() == 0) check("unexpected_pulse", {30'd0, iwait, dwait}, 32'd3);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_side", {30'd0, iwait, dwait}, e.d ? 32'd2 : 32'd1);
        check("ram_addr", ramaddr, e.addr);
        check("ram_strobes", {30'd0, ramREN, ramWEN}, e.wr ? 32'd1 : 32'd2);
        check("load", e.d ? dload : iload, e.load);
        check("other_load", e.d ? iload : dload, 32'd0);
        if (e.wr) check("ram_store", ramstore, e.store);
      end
    end
  initial begin
    int m;
    do_reset();
    check_idle("reset");
    check("reset_addr", ramaddr, 32'd0);
    check("reset_store", ramstore, 32'd0);
    check("reset_timeout", {31'd0, timeout}, 32'd0);
    // single instruction fetch
    iREN = 1; iaddr = 32'h40;
    serve(0, 32'h8C010004, 1'b0, 1'b0, 32'h40, 32'h0);
    iREN = 0;
    check_idle("after_fetch");
    // ram_ready while idle must be ignored
    ram_ready = 1; ramload = 32'h12345678;
    check_idle("ready_in_idle");
    tick();
    ram_ready = 0;
    // contention from reset: instruction first, then alternate
    do_reset();
    iREN = 1; iaddr = 32'h80; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    serve(0, 32'h11110000, 1'b0, 1'b0, 32'h80, 32'h0);
    iaddr = 32'h84;
    serve(1, 32'h22220000, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
    daddr = 32'h104; dstore = 32'hCAFEF00D;
    serve(0, 32'h33330000, 1'b0, 1'b0, 32'h84, 32'h0);
    serve(2, 32'h44440000, 1'b1, 1'b1, 32'h104, 32'hCAFEF00D);
    iREN = 0; dWEN = 0;
    check_idle("after_contention");
    // read and write together -> write
    tick();
    dREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'h0BADF00D;
    serve(0, 32'h55550000, 1'b1, 1'b1, 32'h200, 32'h0BADF00D);
    dREN = 0; dWEN = 0;
    // ready on the cycle the watchdog would fire: completion wins
    tick();
    dREN = 1; daddr = 32'h280;
    serve(3, 32'h66660000, 1'b1, 1'b0, 32'h280, 32'h0);
    dREN = 0;
    check("no_abort_timeout", {31'd0, timeout}, 32'd0);
    // watchdog abort after 4 cycles, then re-grant
    tick();
    dREN = 1; daddr = 32'h300;
    tick();
    check("abort_grant", {30'd0, ramREN, ramWEN}, 32'd2);
    m = 0;
    while ((ramREN || ramWEN) && m < 10) begin
      tick();
      m++;
    end
    check("abort_cycles", 32'(m), 32'd4);
    check("abort_timeout", {31'd0, timeout}, 32'd1);
    serve(0, 32'h77770000, 1'b1, 1'b0, 32'h300, 32'h0);
    dREN = 0;
    check("timeout_sticky", {31'd0, timeout}, 32'd1);
    // reset mid-access
    tick();
    dWEN = 1; daddr = 32'h400; dstore = 32'h99999999;
    tick();
    check("pre_reset_strobe", {30'd0, ramREN, ramWEN}, 32'd1);
    RST = 1; dWEN = 0;
    tick();
    RST = 0;
    check_idle("mid_reset");
    check("mid_reset_timeout", {31'd0, timeout}, 32'd0);
    check("mid_reset_addr", ramaddr, 32'd0);
    check("mid_reset_store", ramstore, 32'd0);
    tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
